// File: rtl/spi_regfile_pkg.sv
// spi_regfile_pkg: shared types and constants for the SPI register-file slave.
//   state_t          - protocol FSM state encoding
//   WRITE_BIT etc.   - bit positions inside the command byte
//   cmd_is_access()  - true when a command byte requests a read and/or write
package spi_regfile_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMMAND = 2'd1,
    ST_ADDRESS = 2'd2,
    ST_DATA    = 2'd3
  } state_t;

  localparam int WRITE_BIT = 7;
  localparam int READ_BIT  = 6;
  localparam int COUNT_MSB = 5;
  localparam int COUNT_LSB = 3;

  // A command with neither read nor write set is a no-op filler byte.
  function automatic logic cmd_is_access(input logic [7:0] cmd);
    return cmd[WRITE_BIT] | cmd[READ_BIT];
  endfunction

endpackage

// File: rtl/spi_regfile_slave_if.sv
// spi_regfile_slave_if: register-file access bus between the SPI slave and
// an external register file.
//   reg_addr  - register address for the current access
//   reg_wdata - write data, valid while reg_we is high
//   reg_we    - one-clock write strobe
//   reg_re    - one-clock read strobe
//   reg_rdata - read data, valid one clock after reg_re
// modport master: the SPI slave (drives address/strobes).
// modport slave : the register file (returns read data).
interface spi_regfile_slave_if #(
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [7:0]            reg_wdata;
  logic                  reg_we;
  logic                  reg_re;
  logic [7:0]            reg_rdata;

  modport master (
    output reg_addr,
    output reg_wdata,
    output reg_we,
    output reg_re,
    input  reg_rdata
  );

  modport slave (
    input  reg_addr,
    input  reg_wdata,
    input  reg_we,
    input  reg_re,
    output reg_rdata
  );
endinterface

// File: rtl/spi_input_sync.sv
// spi_input_sync: brings the asynchronous SPI pins into the clock domain.
//   clock, RSTB - system clock, async active-low reset
//   sck/csb/sdi - raw SPI pins
//   csb_sync    - synchronized chip select
//   sdi_sync    - synchronized data in (aligned with the SCK edge pulses)
//   sck_rise    - one-clock pulse on a detected SCK rising edge
//   sck_fall    - one-clock pulse on a detected SCK falling edge
//   csb_fall    - one-clock pulse on a detected CSB falling edge
module spi_input_sync (
  input  logic clock,
  input  logic RSTB,
  input  logic sck,
  input  logic csb,
  input  logic sdi,
  output logic csb_sync,
  output logic sdi_sync,
  output logic sck_rise,
  output logic sck_fall,
  output logic csb_fall
);

  logic [1:0] sck_meta_r;
  logic [1:0] csb_meta_r;
  logic [1:0] sdi_meta_r;
  logic       sck_prev_r;
  logic       csb_prev_r;

  // Two-flop synchronizers plus one history flop for edge detection.
  always_ff @(posedge clock or negedge RSTB) begin
    if (!RSTB) begin
      sck_meta_r <= 2'b00;
      csb_meta_r <= 2'b11;
      sdi_meta_r <= 2'b00;
      sck_prev_r <= 1'b0;
      csb_prev_r <= 1'b1;
    end else begin
      sck_meta_r <= {sck_meta_r[0], sck};
      csb_meta_r <= {csb_meta_r[0], csb};
      sdi_meta_r <= {sdi_meta_r[0], sdi};
      sck_prev_r <= sck_meta_r[1];
      csb_prev_r <= csb_meta_r[1];
    end
  end

  assign csb_sync = csb_meta_r[1];
  assign sdi_sync = sdi_meta_r[1];
  assign sck_rise = sck_meta_r[1] & ~sck_prev_r;
  assign sck_fall = ~sck_meta_r[1] & sck_prev_r;
  assign csb_fall = ~csb_meta_r[1] & csb_prev_r;

endmodule

// File: rtl/spi_regfile_slave.sv
// spi_regfile_slave: SPI mode-0 slave giving byte access to an external
// register file. Protocol per CSB-low frame: command byte, address byte,
// then data bytes (count from the command, 0 = stream until CSB rises).
//   clock, RSTB  - system clock, async active-low reset
//   SCK/CSB/SDI  - SPI clock, chip select (active-low), data in (MSB first)
//   SDO, SDO_enb - SPI data out (MSB first) and its active-low enable
//   reg_bus      - register-file access bus (master side)
module spi_regfile_slave
  import spi_regfile_pkg::*;
#(
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       RSTB,
  input  logic                       SCK,
  input  logic                       CSB,
  input  logic                       SDI,
  output logic                       SDO,
  output logic                       SDO_enb,
  spi_regfile_slave_if.master        reg_bus
);

  localparam logic [31:0] NUM_REGS_W = 32'(NUM_REGS);

  // Addresses at or above NUM_REGS are unimplemented: no strobes, reads as zero.
  function automatic logic addr_valid(input logic [ADDR_WIDTH-1:0] a);
    return (32'(a) < NUM_REGS_W);
  endfunction

  // The last implemented register wraps to 0; anything else counts up freely.
  function automatic logic [ADDR_WIDTH-1:0] addr_next(input logic [ADDR_WIDTH-1:0] a);
    if (32'(a) == (NUM_REGS_W - 32'd1)) begin
      return {ADDR_WIDTH{1'b0}};
    end else begin
      return a + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    end
  endfunction

  logic csb_s, sdi_s, sck_rise_s, sck_fall_s, csb_fall_s;

  spi_input_sync u_sync (
    .clock    (clock),
    .RSTB     (RSTB),
    .sck      (SCK),
    .csb      (CSB),
    .sdi      (SDI),
    .csb_sync (csb_s),
    .sdi_sync (sdi_s),
    .sck_rise (sck_rise_s),
    .sck_fall (sck_fall_s),
    .csb_fall (csb_fall_s)
  );

  state_t                state_r, state_next_s;
  logic [2:0]            bit_cnt_r;
  logic [7:0]            shift_r;
  logic [7:0]            tx_r;
  logic                  wr_r, rd_r;
  logic [2:0]            count_r, rem_r;
  logic [ADDR_WIDTH-1:0] reg_addr_r;
  logic [7:0]            reg_wdata_r;
  logic                  reg_we_r, reg_re_r, re_d_r;
  logic                  inc_pend_r, inc_re_r;
  logic                  sdo_r, sdo_enb_r;

  logic                  active_s, byte_done_s, last_byte_s, cmd_accept_s, drive_s;
  logic [7:0]            rx_byte_s;
  logic [ADDR_WIDTH-1:0] rx_addr_s, addr_next_s, rd_addr_s;
  logic                  we_set_s, re_set_s, tx_zero_s, rd_issue_s;
  logic                  addr_load_s, addr_inc_s, inc_pend_set_s;

  assign active_s     = (state_r != ST_IDLE) && !csb_s;
  assign byte_done_s  = active_s && sck_rise_s && (bit_cnt_r == 3'd7);
  assign rx_byte_s    = {shift_r[6:0], sdi_s};
  assign rx_addr_s    = rx_byte_s[ADDR_WIDTH-1:0];
  assign addr_next_s  = addr_next(reg_addr_r);
  assign last_byte_s  = (count_r != 3'd0) && (rem_r == 3'd1);
  assign cmd_accept_s = byte_done_s && (state_r == ST_COMMAND) && cmd_is_access(rx_byte_s);
  assign drive_s      = (state_r == ST_DATA) && rd_r && !csb_s;

  // FSM state register.
  always_ff @(posedge clock or negedge RSTB) begin
    if (!RSTB) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; CSB high always returns to IDLE.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (csb_fall_s) state_next_s = ST_COMMAND;
        else            state_next_s = ST_IDLE;
      end
      ST_COMMAND: begin
        if (csb_s)             state_next_s = ST_IDLE;
        else if (cmd_accept_s) state_next_s = ST_ADDRESS;
        else                   state_next_s = ST_COMMAND;
      end
      ST_ADDRESS: begin
        if (csb_s)            state_next_s = ST_IDLE;
        else if (byte_done_s) state_next_s = ST_DATA;
        else                  state_next_s = ST_ADDRESS;
      end
      ST_DATA: begin
        if (csb_s)                           state_next_s = ST_IDLE;
        else if (byte_done_s && last_byte_s) state_next_s = ST_COMMAND;
        else                                 state_next_s = ST_DATA;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM output decode. A write byte strobes reg_we first and defers the
  // address increment (and any next read) by one clock, so a read+write
  // access never raises reg_we and reg_re together.
  always_comb begin
    we_set_s       = 1'b0;
    addr_load_s    = 1'b0;
    addr_inc_s     = 1'b0;
    inc_pend_set_s = 1'b0;
    rd_issue_s     = 1'b0;
    rd_addr_s      = reg_addr_r;
    re_set_s       = 1'b0;
    tx_zero_s      = 1'b0;
    if (byte_done_s && (state_r == ST_ADDRESS)) begin
      addr_load_s = 1'b1;
      rd_issue_s  = rd_r;
      rd_addr_s   = rx_addr_s;
    end else if (byte_done_s && (state_r == ST_DATA) && wr_r) begin
      we_set_s       = addr_valid(reg_addr_r);
      inc_pend_set_s = 1'b1;
    end else if (byte_done_s && (state_r == ST_DATA)) begin
      addr_inc_s = 1'b1;
      rd_issue_s = rd_r && !last_byte_s;
      rd_addr_s  = addr_next_s;
    end else if (inc_pend_r) begin
      addr_inc_s = 1'b1;
      rd_issue_s = inc_re_r && !csb_s;
      rd_addr_s  = addr_next_s;
    end else begin
      rd_issue_s = 1'b0;
    end
    re_set_s  = rd_issue_s && addr_valid(rd_addr_s);
    tx_zero_s = rd_issue_s && !addr_valid(rd_addr_s);
  end

  // Datapath: shifters, command latch, address, strobes and SPI output.
  always_ff @(posedge clock or negedge RSTB) begin
    if (!RSTB) begin
      bit_cnt_r   <= 3'd0;
      shift_r     <= 8'h00;
      tx_r        <= 8'h00;
      wr_r        <= 1'b0;
      rd_r        <= 1'b0;
      count_r     <= 3'd0;
      rem_r       <= 3'd0;
      reg_addr_r  <= {ADDR_WIDTH{1'b0}};
      reg_wdata_r <= 8'h00;
      reg_we_r    <= 1'b0;
      reg_re_r    <= 1'b0;
      re_d_r      <= 1'b0;
      inc_pend_r  <= 1'b0;
      inc_re_r    <= 1'b0;
      sdo_r       <= 1'b0;
      sdo_enb_r   <= 1'b1;
    end else begin
      reg_we_r   <= we_set_s;
      reg_re_r   <= re_set_s;
      re_d_r     <= reg_re_r;
      inc_pend_r <= inc_pend_set_s;
      if (inc_pend_set_s) inc_re_r <= rd_r && !last_byte_s;

      if (we_set_s) reg_wdata_r <= rx_byte_s;

      if (addr_load_s)     reg_addr_r <= rx_addr_s;
      else if (addr_inc_s) reg_addr_r <= addr_next_s;

      // Partial bytes are dropped whenever the frame is not active.
      if (!active_s) begin
        bit_cnt_r <= 3'd0;
        shift_r   <= 8'h00;
      end else if (sck_rise_s) begin
        bit_cnt_r <= bit_cnt_r + 3'd1;
        shift_r   <= rx_byte_s;
      end

      if (cmd_accept_s) begin
        wr_r    <= rx_byte_s[WRITE_BIT];
        rd_r    <= rx_byte_s[READ_BIT];
        count_r <= rx_byte_s[COUNT_MSB:COUNT_LSB];
        rem_r   <= rx_byte_s[COUNT_MSB:COUNT_LSB];
      end else if (byte_done_s && (state_r == ST_DATA) && (count_r != 3'd0)) begin
        rem_r <= rem_r - 3'd1;
      end

      // Read data lands the clock after reg_re. The fall that follows a
      // byte boundary (bit_cnt 0) only presents the MSB; later falls shift.
      if (re_d_r) begin
        tx_r <= reg_bus.reg_rdata;
      end else if (tx_zero_s) begin
        tx_r <= 8'h00;
      end else if (sck_fall_s && (state_r == ST_DATA) && (bit_cnt_r != 3'd0)) begin
        tx_r <= {tx_r[6:0], 1'b0};
      end

      sdo_enb_r <= !drive_s;
      sdo_r     <= drive_s ? tx_r[7] : 1'b0;
    end
  end

  assign SDO               = sdo_r;
  assign SDO_enb           = sdo_enb_r;
  assign reg_bus.reg_addr  = reg_addr_r;
  assign reg_bus.reg_wdata = reg_wdata_r;
  assign reg_bus.reg_we    = reg_we_r;
  assign reg_bus.reg_re    = reg_re_r;

endmodule

// File: tb/tb_spi_regfile_slave.sv
// tb_spi_regfile_slave: drives SPI frames into spi_regfile_slave against a
// 16x8 register-file model. Expected register writes and expected SDO bytes
// are queued when the stimulus is issued and compared as the DUT produces them.
module tb_spi_regfile_slave;

  localparam int HALF = 8;  // clocks per SCK half period

  logic clock = 1'b0;
  logic RSTB, SCK, CSB, SDI;
  logic SDO, SDO_enb;

  spi_regfile_slave_if #(.ADDR_WIDTH(8)) reg_bus ();

  spi_regfile_slave #(.NUM_REGS(16), .ADDR_WIDTH(8)) dut (
    .clock   (clock),
    .RSTB    (RSTB),
    .SCK     (SCK),
    .CSB     (CSB),
    .SDI     (SDI),
    .SDO     (SDO),
    .SDO_enb (SDO_enb),
    .reg_bus (reg_bus)
  );

  always #5 clock = ~clock;

  // Register-file model: read data registered one clock after reg_re.
  logic [7:0] mem [16] = '{default: 8'h00};
  logic [7:0] rdata_r = 8'h00;
  assign reg_bus.reg_rdata = rdata_r;

  always @(posedge clock) begin
    if (reg_bus.reg_we && (reg_bus.reg_addr < 8'd16)) mem[reg_bus.reg_addr[3:0]] <= reg_bus.reg_wdata;
    if (reg_bus.reg_re) rdata_r <= (reg_bus.reg_addr < 8'd16) ? mem[reg_bus.reg_addr[3:0]] : 8'h00;
  end

  int checks_cnt = 0;
  int errors_cnt = 0;
  int we_cnt = 0;
  int re_cnt = 0;
  logic [15:0] wr_exp_q [$];
  logic [7:0]  rd_exp_q [$];
  logic [15:0] wr_exp_v;
  logic [7:0]  exp_035 [7] = '{8'hAA, 8'h55, 8'h12, 8'h0F, 8'h67, 8'h25, 8'h38};

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
    checks_cnt++;
    if (obs !== exp_val) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_val);
    end
  endtask

  // Strobe monitor: every reg_we must match the next queued write.
  always @(negedge clock) begin
    if (RSTB) begin
      if (reg_bus.reg_we || reg_bus.reg_re)
        check_value("we_re_excl", {31'd0, reg_bus.reg_we & reg_bus.reg_re}, 32'd0);
      if (reg_bus.reg_re) re_cnt++;
      if (reg_bus.reg_we) begin
        we_cnt++;
        if (wr_exp_q.size() == 0) begin
          check_value("we_unexpected", {24'd0, reg_bus.reg_addr}, 32'hFFFF_FFFF);
        end else begin
          wr_exp_v = wr_exp_q.pop_front();
          check_value("we_addr", {24'd0, reg_bus.reg_addr}, {24'd0, wr_exp_v[15:8]});
          check_value("we_data", {24'd0, reg_bus.reg_wdata}, {24'd0, wr_exp_v[7:0]});
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Mode-0 master: SDI set while SCK low, SDO sampled at the SCK rise.
  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      SDI = tx[i];
      wait_clk(HALF);
      SCK = 1'b1;
      rx[i] = SDO;
      wait_clk(HALF);
      SCK = 1'b0;
    end
  endtask

  task automatic xfer_byte(input logic [7:0] tx, input bit chk_rd, input string tag);
    logic [7:0] rx;
    spi_bits(tx, 8, rx);
    if (chk_rd) begin
      if (rd_exp_q.size() == 0) check_value({tag, "_underflow"}, {24'd0, rx}, 32'hFFFF_FFFF);
      else check_value(tag, {24'd0, rx}, {24'd0, rd_exp_q.pop_front()});
    end
  endtask

  task automatic cs_begin();
    CSB = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_end();
    wait_clk(HALF);
    CSB = 1'b1;
    wait_clk(2 * HALF);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_value({tag, "_sdo"},   {31'd0, SDO}, 32'd0);
    check_value({tag, "_enb"},   {31'd0, SDO_enb}, 32'd1);
    check_value({tag, "_we"},    {31'd0, reg_bus.reg_we}, 32'd0);
    check_value({tag, "_re"},    {31'd0, reg_bus.reg_re}, 32'd0);
    check_value({tag, "_addr"},  {24'd0, reg_bus.reg_addr}, 32'd0);
    check_value({tag, "_wdata"}, {24'd0, reg_bus.reg_wdata}, 32'd0);
  endtask

  initial begin
    int we_before;
    int re_before;
    logic [7:0] dummy;
    RSTB = 1'b0; SCK = 1'b0; CSB = 1'b1; SDI = 1'b0;
    wait_clk(4);
    check_reset_outputs("rst");
    RSTB = 1'b1;
    wait_clk(4);

    // Single write of 0xF0 to reg 0.
    wr_exp_q.push_back({8'h00, 8'hF0});
    cs_begin();
    xfer_byte(8'h88, 1'b0, ""); xfer_byte(8'h00, 1'b0, ""); xfer_byte(8'hF0, 1'b0, "");
    cs_end();
    check_value("t1_we_cnt", we_cnt, 32'd1);
    check_value("t1_reg0", {24'd0, mem[0]}, 32'hF0);

    // No-op, counted write of 3, streamed write of 4, all in one frame.
    wr_exp_q.push_back({8'h01, 8'hAA}); wr_exp_q.push_back({8'h02, 8'h55});
    wr_exp_q.push_back({8'h03, 8'h12}); wr_exp_q.push_back({8'h04, 8'h0F});
    wr_exp_q.push_back({8'h05, 8'h67}); wr_exp_q.push_back({8'h06, 8'h25});
    wr_exp_q.push_back({8'h07, 8'h38});
    cs_begin();
    xfer_byte(8'h00, 1'b0, ""); xfer_byte(8'h98, 1'b0, ""); xfer_byte(8'h01, 1'b0, "");
    xfer_byte(8'hAA, 1'b0, ""); xfer_byte(8'h55, 1'b0, ""); xfer_byte(8'h12, 1'b0, "");
    xfer_byte(8'h80, 1'b0, ""); xfer_byte(8'h04, 1'b0, "");
    xfer_byte(8'h0F, 1'b0, ""); xfer_byte(8'h67, 1'b0, ""); xfer_byte(8'h25, 1'b0, "");
    xfer_byte(8'h38, 1'b0, "");
    cs_end();
    for (int i = 0; i < 7; i++)
      check_value($sformatf("t2_reg%0d", i + 1), {24'd0, mem[i + 1]}, {24'd0, exp_035[i]});

    // Preload reg 15 for the wrapping read stream.
    wr_exp_q.push_back({8'h0F, 8'h5A});
    cs_begin();
    xfer_byte(8'h88, 1'b0, ""); xfer_byte(8'h0F, 1'b0, ""); xfer_byte(8'h5A, 1'b0, "");
    cs_end();

    // Count=1 write followed by an unfinished new command.
    we_before = we_cnt;
    wr_exp_q.push_back({8'h08, 8'h11});
    cs_begin();
    xfer_byte(8'h88, 1'b0, ""); xfer_byte(8'h08, 1'b0, ""); xfer_byte(8'h11, 1'b0, "");
    xfer_byte(8'h88, 1'b0, "");
    cs_end();
    check_value("t3_reg8", {24'd0, mem[8]}, 32'h11);
    check_value("t3_reg9", {24'd0, mem[9]}, 32'h00);
    check_value("t3_we_delta", we_cnt - we_before, 32'd1);

    // Read stream from 15 wrapping to 0 and 1.
    rd_exp_q.push_back(8'h5A); rd_exp_q.push_back(8'hF0); rd_exp_q.push_back(8'hAA);
    cs_begin();
    xfer_byte(8'h40, 1'b0, ""); xfer_byte(8'h0F, 1'b0, "");
    xfer_byte(8'h00, 1'b1, "t4_rd15");
    check_value("t4_enb_active", {31'd0, SDO_enb}, 32'd0);
    xfer_byte(8'h00, 1'b1, "t4_rd0");
    xfer_byte(8'h00, 1'b1, "t4_rd1");
    cs_end();
    check_value("t4_enb_idle", {31'd0, SDO_enb}, 32'd1);
    check_value("t4_sdo_idle", {31'd0, SDO}, 32'd0);

    // Read+write on reg 2, then a read of an unimplemented address.
    wr_exp_q.push_back({8'h02, 8'h3C});
    rd_exp_q.push_back(8'h55);
    cs_begin();
    xfer_byte(8'hC8, 1'b0, ""); xfer_byte(8'h02, 1'b0, ""); xfer_byte(8'h3C, 1'b1, "t5_rw");
    wait_clk(4);
    re_before = re_cnt;
    rd_exp_q.push_back(8'h00);
    xfer_byte(8'h48, 1'b0, ""); xfer_byte(8'h20, 1'b0, ""); xfer_byte(8'hFF, 1'b1, "t5_rd_oob");
    cs_end();
    check_value("t5_reg2", {24'd0, mem[2]}, 32'h3C);
    check_value("t5_no_re", re_cnt - re_before, 32'd0);

    // Reset in the middle of a write data byte.
    we_before = we_cnt;
    cs_begin();
    xfer_byte(8'h88, 1'b0, ""); xfer_byte(8'h03, 1'b0, "");
    spi_bits(8'hC3, 4, dummy);
    RSTB = 1'b0;
    wait_clk(2);
    check_reset_outputs("t6_rst");
    CSB = 1'b1;
    wait_clk(4);
    RSTB = 1'b1;
    wait_clk(4 * HALF);
    check_value("t6_we_delta", we_cnt - we_before, 32'd0);
    check_value("t6_reg3_kept", {24'd0, mem[3]}, 32'h12);
    wr_exp_q.push_back({8'h03, 8'h99});
    cs_begin();
    xfer_byte(8'h88, 1'b0, ""); xfer_byte(8'h03, 1'b0, ""); xfer_byte(8'h99, 1'b0, "");
    cs_end();
    check_value("t6_reg3", {24'd0, mem[3]}, 32'h99);

    check_value("wr_q_empty", wr_exp_q.size(), 32'd0);
    check_value("rd_q_empty", rd_exp_q.size(), 32'd0);
    check_value("we_total", we_cnt, 32'd12);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
